// File: rtl/mod10_pkg.sv
// Shared constants for the decade (BCD) counter.
// Width, terminal count and reset value of one BCD digit.
package mod10_pkg;

   localparam int unsigned CNT_W   = 4;
   localparam logic [3:0]  CNT_MAX = 4'd9;
   localparam logic [3:0]  CNT_RST = 4'd0;

endpackage

// File: rtl/t_ff_ar.sv
// T flip-flop with asynchronous active-high reset.
// Its simulation initial value is 0, so an un-reset bench starts counting from 0.
module t_ff_ar (
   input  logic clk,
   input  logic rst,
   input  logic t,
   output logic q
);

   logic state_q = 1'b0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= 1'b0;
      end else if (t) begin
         state_q <= ~state_q;
      end
   end

   assign q = state_q;

endmodule

// File: rtl/mod10_sync_counter.sv
// Synchronous decade up-counter built from four T flip-flops on one clock.
// Counts 0..9 and wraps; any state 10..15 returns to 0 on the next edge.
module mod10_sync_counter
   import mod10_pkg::*;
#(
   parameter int unsigned      WIDTH   = CNT_W,
   parameter logic [CNT_W-1:0] MAX_VAL = CNT_MAX
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   if (WIDTH != CNT_W || MAX_VAL != CNT_MAX) begin : g_bad_param
      $error("mod10_sync_counter supports only WIDTH=4, MAX_VAL=9");
   end

   logic [CNT_W-1:0] q;
   logic [CNT_W-1:0] t_cnt;
   logic [CNT_W-1:0] t;
   logic             illegal;

   always_comb begin
      t_cnt    = '0;
      t_cnt[0] = 1'b1;
      t_cnt[1] = q[0] & ~q[3];
      t_cnt[2] = q[0] & q[1];
      t_cnt[3] = (q[0] & q[1] & q[2]) | (q[0] & q[3]);
      illegal  = q[3] & (q[2] | q[1]);
      // Loading 0 into a T flop means toggling exactly the bits that are set.
      t        = illegal ? q : t_cnt;
   end

   t_ff_ar u_b0 (.clk(clk), .rst(reset), .t(t[0]), .q(q[0]));
   t_ff_ar u_b1 (.clk(clk), .rst(reset), .t(t[1]), .q(q[1]));
   t_ff_ar u_b2 (.clk(clk), .rst(reset), .t(t[2]), .q(q[2]));
   t_ff_ar u_b3 (.clk(clk), .rst(reset), .t(t[3]), .q(q[3]));

   assign out = q;

endmodule

// File: tb/tb_mod10_sync_counter.sv
// Scoreboard bench for mod10_sync_counter: stimulus queues expected counts,
// a monitor pops and compares at each sample point.
module tb_mod10_sync_counter;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] exp_q[$];
   string      name_q[$];
   event       sample_ev;

   mod10_sync_counter dut (
      .clk  (clk),
      .reset(reset),
      .out  (out)
   );

   always #5 clk = ~clk;

   // Monitor: one comparison per sample event.
   initial begin
      logic [3:0] e;
      string      nm;
      forever begin
         @(sample_ev);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: sample with empty scoreboard, out=%0d", "sb_empty", out);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (out !== e) begin
               n_bad++;
               $display("FAIL %s @%0t: out=%0d required=%0d", nm, $time, out, e);
            end
         end
      end
   end

   task automatic expect_now(input logic [3:0] v, input string nm);
      exp_q.push_back(v);
      name_q.push_back(nm);
      ->sample_ev;
      #0;
   endtask

   task automatic edge_expect(input logic [3:0] v, input string nm);
      @(posedge clk);
      #1;
      expect_now(v, nm);
   endtask

   task automatic deposit(input logic [3:0] v);
      logic [3:0] dv;
      dv = v;
      force dut.u_b0.state_q = dv[0];
      force dut.u_b1.state_q = dv[1];
      force dut.u_b2.state_q = dv[2];
      force dut.u_b3.state_q = dv[3];
      #0;
      release dut.u_b0.state_q;
      release dut.u_b1.state_q;
      release dut.u_b2.state_q;
      release dut.u_b3.state_q;
   endtask

   initial begin
      // 1. power-up count without reset: edges 5..125 give 1..9,0,1,2,3
      for (int k = 1; k <= 13; k++) begin
         edge_expect(4'(k % 10), "powerup_count");
      end
      // 2. async reset at t=130
      #3;
      reset = 1'b1;
      #1;
      expect_now(4'd0, "async_reset");
      // 3. held over edge at 135, released at 140
      edge_expect(4'd0, "reset_hold");
      #3;
      reset = 1'b0;
      edge_expect(4'd1, "first_after_release");
      // 4. free run to 9 at 225 and wrap at 235
      for (int k = 2; k <= 9; k++) begin
         edge_expect(4'(k), "free_run");
      end
      edge_expect(4'd0, "wrap_9_to_0");
      // 5. reset while out = 9
      for (int k = 1; k <= 9; k++) begin
         edge_expect(4'(k), "run_to_9");
      end
      #3;
      reset = 1'b1;
      #1;
      expect_now(4'd0, "reset_at_9");
      edge_expect(4'd0, "reset_hold_9");
      #3;
      reset = 1'b0;
      edge_expect(4'd1, "release_after_9");
      // 6. illegal states self-correct within one edge
      for (int v = 10; v <= 15; v++) begin
         #2;
         deposit(4'(v));
         #1;
         expect_now(4'(v), "deposit_value");
         edge_expect(4'd0, "illegal_to_0");
         edge_expect(4'd1, "after_illegal");
      end
      #2;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: %0d entries left, required 0", "sb_drain", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL %s: time limit reached", "timeout");
      $fatal(1, "timeout");
   end

endmodule
